// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM_OP load/store sequencer over a req/gnt/rvalid bus.
// Build option MISALIGNED_SPLIT_EN splits misaligned accesses instead of trapping.
module mem_access_unit #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_type,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [31:0]       rsp_cause,
    output logic              busy,
    output logic              mem_req,
    input  logic              mem_gnt,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam int CW    = (CNT_W < 1) ? 1 : CNT_W;

    localparam logic [1:0] SZ_BYTE = 2'b11;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

`ifdef MISALIGNED_SPLIT_EN
    localparam bit SPLIT = 1'b1;
    typedef enum logic [2:0] {
        IDLE, BUS_REQ, BUS_WAIT, RESP, BUS_REQ2, BUS_WAIT2
    } state_t;
`else
    localparam bit SPLIT = 1'b0;
    typedef enum logic [2:0] {
        IDLE, BUS_REQ, BUS_WAIT, RESP
    } state_t;
`endif

    state_t            state, state_nx;
    logic              r_load, r_uns;
    logic [1:0]        r_size;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [CW-1:0]     cnt;
    logic [31:0]       rdata_q;
    logic              err_q;
    logic [2:0]        cause_q;

    logic              accept, in_nop, in_misal, tmo;
    logic [1:0]        off;
    logic [3:0]        be_base, be_lo;
    logic [31:0]       wd_rep, wd_lo;
    logic [ADDR_W-1:0] word_addr;

    assign accept    = req_valid && (state == IDLE);
    assign in_nop    = (req_type[2:1] == 2'b00);
    assign in_misal  = ((req_type[2:1] == SZ_HALF) && req_addr[0]) ||
                       ((req_type[2:1] == SZ_WORD) && (req_addr[1:0] != 2'b00));
    assign tmo       = (TIMEOUT != 0) && (cnt == CW'(TIMEOUT - 1));
    assign off       = r_addr[1:0];
    assign word_addr = {r_addr[ADDR_W-1:2], 2'b00};

    always_comb begin
        be_base = 4'b0000;
        wd_rep  = r_wdata;
        case (r_size)
            SZ_BYTE: begin
                be_base = 4'b0001;
                wd_rep  = {4{r_wdata[7:0]}};
            end
            SZ_HALF: begin
                be_base = 4'b0011;
                wd_rep  = {2{r_wdata[15:0]}};
            end
            SZ_WORD: be_base = 4'b1111;
            default: be_base = 4'b0000;
        endcase
    end

`ifdef MISALIGNED_SPLIT_EN
    logic        r_misal, r_cross;
    logic [7:0]  be8;
    logic [3:0]  be_hi;
    logic [31:0] wd_raw, wd_hi, lo_q;
    logic [63:0] w64;

    assign r_misal = ((r_size == SZ_HALF) && off[0]) ||
                     ((r_size == SZ_WORD) && (off != 2'b00));
    assign r_cross = ((r_size == SZ_HALF) && (off == 2'b11)) ||
                     ((r_size == SZ_WORD) && (off != 2'b00));
    assign be8     = {4'b0000, be_base} << off;
    assign be_lo   = be8[3:0];
    assign be_hi   = be8[7:4];
    assign wd_raw  = (r_size == SZ_BYTE) ? {24'b0, r_wdata[7:0]} :
                     (r_size == SZ_HALF) ? {16'b0, r_wdata[15:0]} : r_wdata;
    assign w64     = {32'b0, wd_raw} << {off, 3'b000};
    assign wd_lo   = r_misal ? w64[31:0] : wd_rep;
    assign wd_hi   = w64[63:32];
`else
    assign be_lo   = be_base << off;
    assign wd_lo   = wd_rep;
`endif

    // Lanes are taken from a 64-bit window so split loads merge before extension.
    function automatic logic [31:0] extract(input logic [63:0] w,
                                            input logic [1:0]  sz,
                                            input logic [1:0]  o,
                                            input logic        uns);
        logic [63:0] s;
        s = w >> {o, 3'b000};
        case (sz)
            SZ_BYTE: extract = {{24{~uns & s[7]}}, s[7:0]};
            SZ_HALF: extract = {{16{~uns & s[15]}}, s[15:0]};
            default: extract = s[31:0];
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    if (in_nop || (in_misal && !SPLIT)) state_nx = RESP;
                    else                                state_nx = BUS_REQ;
                end
            end
            BUS_REQ: begin
                if (mem_gnt)  state_nx = BUS_WAIT;
                else if (tmo) state_nx = RESP;
            end
            BUS_WAIT: begin
                if (mem_rvalid) begin
`ifdef MISALIGNED_SPLIT_EN
                    state_nx = (!mem_err && r_cross) ? BUS_REQ2 : RESP;
`else
                    state_nx = RESP;
`endif
                end else if (tmo) begin
                    state_nx = RESP;
                end
            end
`ifdef MISALIGNED_SPLIT_EN
            BUS_REQ2: begin
                if (mem_gnt)  state_nx = BUS_WAIT2;
                else if (tmo) state_nx = RESP;
            end
            BUS_WAIT2: begin
                if (mem_rvalid || tmo) state_nx = RESP;
            end
`endif
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_load  <= 1'b0;
            r_uns   <= 1'b0;
            r_size  <= 2'b00;
            r_addr  <= '0;
            r_wdata <= '0;
            cnt     <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cause_q <= 3'd0;
`ifdef MISALIGNED_SPLIT_EN
            lo_q    <= '0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        r_load  <= req_type[3];
                        r_uns   <= req_type[0];
                        r_size  <= req_type[2:1];
                        r_addr  <= req_addr;
                        r_wdata <= req_wdata;
                        cnt     <= '0;
                        rdata_q <= '0;
                        err_q   <= in_misal && !SPLIT;
                        cause_q <= (in_misal && !SPLIT) ?
                                   (req_type[3] ? 3'd4 : 3'd6) : 3'd0;
                    end
                end
`ifdef MISALIGNED_SPLIT_EN
                BUS_REQ, BUS_REQ2: begin
`else
                BUS_REQ: begin
`endif
                    cnt <= cnt + 1'b1;
                    if (!mem_gnt && tmo) begin
                        err_q   <= 1'b1;
                        cause_q <= r_load ? 3'd5 : 3'd7;
                    end
                end
                BUS_WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (mem_rvalid) begin
                        if (mem_err) begin
                            err_q   <= 1'b1;
                            cause_q <= r_load ? 3'd5 : 3'd7;
`ifdef MISALIGNED_SPLIT_EN
                        end else if (r_cross) begin
                            lo_q <= mem_rdata;
                            cnt  <= '0;
`endif
                        end else if (r_load) begin
                            rdata_q <= extract({32'b0, mem_rdata}, r_size, off, r_uns);
                        end
                    end else if (tmo) begin
                        err_q   <= 1'b1;
                        cause_q <= r_load ? 3'd5 : 3'd7;
                    end
                end
`ifdef MISALIGNED_SPLIT_EN
                BUS_WAIT2: begin
                    cnt <= cnt + 1'b1;
                    if ((mem_rvalid && mem_err) || (!mem_rvalid && tmo)) begin
                        err_q   <= 1'b1;
                        cause_q <= r_load ? 3'd5 : 3'd7;
                    end else if (mem_rvalid && r_load) begin
                        rdata_q <= extract({mem_rdata, lo_q}, r_size, off, r_uns);
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    always_comb begin
        req_ready = (state == IDLE);
        busy      = (state != IDLE);
        rsp_valid = (state == RESP);
        rsp_rdata = rsp_valid ? rdata_q : '0;
        rsp_err   = rsp_valid && err_q;
        rsp_cause = rsp_valid ? {29'b0, cause_q} : '0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_be    = 4'b0000;
        mem_addr  = '0;
        mem_wdata = '0;
        if (state == BUS_REQ) begin
            mem_req   = 1'b1;
            mem_we    = !r_load;
            mem_be    = be_lo;
            mem_addr  = word_addr;
            mem_wdata = wd_lo;
        end
`ifdef MISALIGNED_SPLIT_EN
        if (state == BUS_REQ2) begin
            mem_req   = 1'b1;
            mem_we    = !r_load;
            mem_be    = be_hi;
            mem_addr  = word_addr + ADDR_W'(4);
            mem_wdata = wd_hi;
        end
`endif
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed vector table plus hand sequences for
// timeout, stray responses and reset in mid-transaction.
module tb_mem_access_unit;

    localparam logic [3:0] T_LB  = 4'b1110;
    localparam logic [3:0] T_LBU = 4'b1111;
    localparam logic [3:0] T_LH  = 4'b1010;
    localparam logic [3:0] T_LHU = 4'b1011;
    localparam logic [3:0] T_LW  = 4'b1100;
    localparam logic [3:0] T_SB  = 4'b0110;
    localparam logic [3:0] T_SH  = 4'b0010;
    localparam logic [3:0] T_SW  = 4'b0100;
    localparam logic [3:0] T_NOP = 4'b0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready;
    logic [3:0]  req_type;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata, rsp_cause;
    logic        busy, mem_req, mem_gnt, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_rvalid, mem_err;
    logic [31:0] mem_rdata;

    int total = 0;
    int bad   = 0;

    logic [31:0] rwords  [2];
    logic [31:0] addr_log[2];
    logic [3:0]  be_log  [2];

    mem_access_unit #(.ADDR_W(32), .TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_type(req_type), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_cause(rsp_cause), .busy(busy),
        .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we),
        .mem_be(mem_be), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  t;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] rd;
        int          gd;
        bit          berr;
        bit          bus;
        logic [3:0]  be;
        logic [31:0] ma;
        logic [31:0] mwd;
        bit          we;
        logic [31:0] rdata;
        bit          err;
        logic [31:0] cause;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int          rspc, rsp_at, reqc;
        bit          granted, rv_sent, busbad, seen;
        logic [31:0] r_rd, r_cause;
        logic        r_err;
        rspc = 0; rsp_at = -1; reqc = 0;
        granted = 0; rv_sent = 0; busbad = 0; seen = 0;
        r_rd = '0; r_cause = '0; r_err = 1'b0;
        @(negedge clk);
        chk($sformatf("v%0d_ready", idx), req_ready, 1);
        req_valid = 1; req_type = v.t; req_addr = v.a; req_wdata = v.wd;
        @(negedge clk);
        req_valid = 0;
        for (int cyc = 1; cyc < 60; cyc++) begin
            mem_gnt = 0; mem_rvalid = 0; mem_err = 0;
            if (mem_req) begin
                seen = 1;
                if (mem_be !== v.be || mem_addr !== v.ma ||
                    mem_we !== v.we || mem_wdata !== v.mwd) busbad = 1;
                if (reqc == v.gd) begin
                    mem_gnt = 1;
                    granted = 1;
                end
                reqc++;
            end else if (granted && !rv_sent) begin
                mem_rvalid = 1; mem_rdata = v.rd; mem_err = v.berr;
                rv_sent = 1;
            end
            if (rsp_valid) begin
                rspc++;
                if (rsp_at < 0) begin
                    rsp_at = cyc; r_rd = rsp_rdata;
                    r_err = rsp_err; r_cause = rsp_cause;
                end
            end
            if (rsp_at >= 0 && cyc > rsp_at) break;
            @(negedge clk);
        end
        mem_gnt = 0; mem_rvalid = 0; mem_err = 0;
        chk($sformatf("v%0d_rsp_count", idx), rspc, 1);
        chk($sformatf("v%0d_rdata", idx), r_rd, v.rdata);
        chk($sformatf("v%0d_err", idx), r_err, v.err);
        if (v.err) chk($sformatf("v%0d_cause", idx), r_cause, v.cause);
        chk($sformatf("v%0d_bus_seen", idx), seen, v.bus);
        if (v.bus) chk($sformatf("v%0d_bus_fields", idx), busbad, 0);
        if (v.bus && v.gd == 0) chk($sformatf("v%0d_latency", idx), rsp_at, 3);
        if (!v.bus) chk($sformatf("v%0d_latency", idx), rsp_at, 1);
    endtask

    task automatic run_raw(input logic [3:0] t, input logic [31:0] a,
                           input bit do_gnt, input bit do_rv, input bit stray,
                           output int nreq, output int at, output int nrsp,
                           output logic [31:0] rd, output logic err,
                           output logic [31:0] cause, output logic req_at_rsp);
        int ntx;
        bit pend;
        nreq = 0; at = -1; nrsp = 0; ntx = 0; pend = 0;
        rd = '0; err = 1'b0; cause = '0; req_at_rsp = 1'b0;
        @(negedge clk);
        req_valid = 1; req_type = t; req_addr = a; req_wdata = '0;
        @(negedge clk);
        req_valid = 0;
        for (int cyc = 1; cyc < 60; cyc++) begin
            mem_gnt = 0; mem_rvalid = 0; mem_err = 0;
            if (mem_req) begin
                nreq++;
                if (do_gnt) begin
                    if (ntx < 2) begin
                        addr_log[ntx] = mem_addr;
                        be_log[ntx]   = mem_be;
                    end
                    mem_gnt = 1;
                    pend = 1;
                end
            end else if (pend && do_rv) begin
                mem_rvalid = 1;
                mem_rdata  = (ntx < 2) ? rwords[ntx] : '0;
                ntx++;
                pend = 0;
            end
            if (rsp_valid) begin
                nrsp++;
                if (at < 0) begin
                    at = cyc; rd = rsp_rdata; err = rsp_err;
                    cause = rsp_cause; req_at_rsp = mem_req;
                end
            end
            if (stray && at >= 0) begin
                mem_rvalid = 1; mem_rdata = 32'hFFFF_FFFF;
            end
            if (at >= 0 && cyc >= at + 2) break;
            @(negedge clk);
        end
        if (!stray) begin
            mem_gnt = 0; mem_rvalid = 0; mem_err = 0;
        end
    endtask

    initial begin
        int          nreq, at, nrsp, late;
        logic [31:0] rd, cause;
        logic        err, rq;

        rst_n = 0; req_valid = 0; req_type = T_NOP;
        req_addr = '0; req_wdata = '0;
        mem_gnt = 0; mem_rvalid = 0; mem_err = 0; mem_rdata = '0;

        vq.push_back('{T_LB,  32'h103, 32'h0, 32'h80FF_0000, 0, 0, 1,
                       4'b1000, 32'h100, 32'h0, 0, 32'hFFFF_FF80, 0, 0});
        vq.push_back('{T_LBU, 32'h103, 32'h0, 32'h80FF_0000, 1, 0, 1,
                       4'b1000, 32'h100, 32'h0, 0, 32'h0000_0080, 0, 0});
        vq.push_back('{T_LH,  32'h102, 32'h0, 32'h80FF_0000, 0, 0, 1,
                       4'b1100, 32'h100, 32'h0, 0, 32'hFFFF_80FF, 0, 0});
        vq.push_back('{T_LHU, 32'h100, 32'h0, 32'h1234_ABCD, 0, 0, 1,
                       4'b0011, 32'h100, 32'h0, 0, 32'h0000_ABCD, 0, 0});
        vq.push_back('{T_LW,  32'h204, 32'h0, 32'hDEAD_BEEF, 2, 0, 1,
                       4'b1111, 32'h204, 32'h0, 0, 32'hDEAD_BEEF, 0, 0});
        vq.push_back('{T_SH,  32'h202, 32'h0000_BEEF, 32'h1234_5678, 0, 0, 1,
                       4'b1100, 32'h200, 32'hBEEF_BEEF, 1, 32'h0, 0, 0});
        vq.push_back('{T_SB,  32'h001, 32'h0000_00A5, 32'hFFFF_FFFF, 0, 0, 1,
                       4'b0010, 32'h000, 32'hA5A5_A5A5, 1, 32'h0, 0, 0});
        vq.push_back('{T_SW,  32'h300, 32'hCAFE_F00D, 32'h0, 3, 1, 1,
                       4'b1111, 32'h300, 32'hCAFE_F00D, 1, 32'h0, 1, 7});
        vq.push_back('{T_LH,  32'h106, 32'h0, 32'h1111_2222, 0, 1, 1,
                       4'b1100, 32'h104, 32'h0, 0, 32'h0, 1, 5});
        vq.push_back('{T_NOP, 32'h055, 32'h1234_5678, 32'h0, 0, 0, 0,
                       4'b0000, 32'h0, 32'h0, 0, 32'h0, 0, 0});
        vq.push_back('{T_LB,  32'h002, 32'h0, 32'h007F_0000, 0, 0, 1,
                       4'b0100, 32'h000, 32'h0, 0, 32'h0000_007F, 0, 0});
`ifndef MISALIGNED_SPLIT_EN
        vq.push_back('{T_LW,  32'h101, 32'h0, 32'h0, 0, 0, 0,
                       4'b0000, 32'h0, 32'h0, 0, 32'h0, 1, 4});
        vq.push_back('{T_SH,  32'h203, 32'h0000_1234, 32'h0, 0, 0, 0,
                       4'b0000, 32'h0, 32'h0, 0, 32'h0, 1, 6});
        vq.push_back('{T_LHU, 32'h0FF, 32'h0, 32'h0, 0, 0, 0,
                       4'b0000, 32'h0, 32'h0, 0, 32'h0, 1, 4});
`endif

        repeat (2) @(negedge clk);
        chk("reset_ready", req_ready, 1);
        chk("reset_busy", busy, 0);
        chk("reset_mem_req", mem_req, 0);
        chk("reset_rsp_valid", rsp_valid, 0);
        rst_n = 1;

        foreach (vq[i]) run_vec(vq[i], i);

        // No grant at all: request must drop after the timeout window.
        run_raw(T_LHU, 32'h110, 0, 0, 0, nreq, at, nrsp, rd, err, cause, rq);
        chk("tmo_req_cycles", nreq, 16);
        chk("tmo_rsp_at", at, 17);
        chk("tmo_rsp_count", nrsp, 1);
        chk("tmo_err", err, 1);
        chk("tmo_cause", cause, 5);
        chk("tmo_req_dropped", rq, 0);

        // Granted but no rvalid, then a late rvalid arrives during RESP/IDLE.
        run_raw(T_LHU, 32'h114, 1, 0, 1, nreq, at, nrsp, rd, err, cause, rq);
        chk("tmo2_rsp_count", nrsp, 1);
        chk("tmo2_err", err, 1);
        chk("tmo2_cause", cause, 5);
        chk("tmo2_rdata", rd, 0);
        run_vec('{T_NOP, 32'h0, 32'hFFFF_FFFF, 32'h0, 0, 0, 0,
                  4'b0000, 32'h0, 32'h0, 0, 32'h0, 0, 0}, 100);

`ifdef MISALIGNED_SPLIT_EN
        rwords[0] = 32'h4433_2211;
        rwords[1] = 32'h0000_0055;
        run_raw(T_LW, 32'h101, 1, 1, 0, nreq, at, nrsp, rd, err, cause, rq);
        chk("split_rsp_count", nrsp, 1);
        chk("split_rdata", rd, 32'h5544_3322);
        chk("split_err", err, 0);
        chk("split_addr0", addr_log[0], 32'h100);
        chk("split_be0", be_log[0], 4'b1110);
        chk("split_addr1", addr_log[1], 32'h104);
        chk("split_be1", be_log[1], 4'b0001);
`endif

        // Reset while the load sits in BUS_WAIT with a response in flight.
        @(negedge clk);
        req_valid = 1; req_type = T_LW; req_addr = 32'h400; req_wdata = '0;
        @(negedge clk);
        req_valid = 0;
        chk("rst_seq_req", mem_req, 1);
        mem_gnt = 1;
        @(negedge clk);
        mem_gnt = 0;
        chk("rst_seq_busy_before", busy, 1);
        rst_n = 0;
        mem_rvalid = 1; mem_rdata = 32'h5A5A_5A5A;
        @(negedge clk);
        chk("rst_seq_ready", req_ready, 1);
        chk("rst_seq_busy", busy, 0);
        chk("rst_seq_rsp_valid", rsp_valid, 0);
        chk("rst_seq_mem_req", mem_req, 0);
        chk("rst_seq_outs_zero",
            |{mem_we, mem_be, mem_addr, mem_wdata, rsp_err, rsp_cause, rsp_rdata}, 0);
        rst_n = 1;
        late = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (rsp_valid) late++;
        end
        mem_rvalid = 0;
        chk("rst_seq_no_rsp", late, 0);

        run_vec('{T_LBU, 32'h001, 32'h0, 32'h0000_9C00, 0, 0, 1,
                  4'b0010, 32'h000, 32'h0, 0, 32'h0000_009C, 0, 0}, 101);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Load/store sequencer for the multicycle core's MEM_OP stage.
- Takes one memory instruction, encoded as a 4-bit mem_inst_type_t, with its address and store data.
- Runs a req/gnt/rvalid bus transaction and returns lane-aligned, sign- or zero-extended load data, or an exception cause in excCause encoding.
- Successor to the fixed-function byte-lane logic: parametrised address width, a bus timeout, and optional splitting of misaligned accesses.

Parameters:
ADDR_W, 32, width of request and bus addresses
TIMEOUT, 16, max cycles from bus request to rvalid before an access fault; 0 disables the timeout
CNT_W, $clog2(TIMEOUT+1), timeout counter width; derived, never overridden

Ports:
clk  in  1  core clock
rst_n  in  1  synchronous active-low reset
req_valid  in  1  request strobe from the control FSM
req_ready  out  1  unit idle, request accepted when valid&&ready
req_type  in  4  mem_inst_type_t (MEM_LB..MEM_SW, MEM_NOP)
req_addr  in  ADDR_W  byte address
req_wdata  in  32  store data, low-aligned
rsp_valid  out  1  one-cycle response pulse
rsp_rdata  out  32  extended load data; 0 for stores, NOP and errors
rsp_err  out  1  exception flag, qualified by rsp_valid
rsp_cause  out  32  4 load-misaligned, 5 load-fault, 6 store-misaligned, 7 store-fault
busy  out  1  state != IDLE
mem_req  out  1  bus request, held until mem_gnt
mem_gnt  in  1  bus grant
mem_we  out  1  write enable
mem_be  out  4  byte enables
mem_addr  out  ADDR_W  word-aligned address (low 2 bits 0)
mem_wdata  out  32  lane-replicated store data
mem_rvalid  in  1  response/ack, for loads and stores
mem_rdata  in  32  read word
mem_err  in  1  bus error, qualified by mem_rvalid

Behaviour:
- Decode of req_type: bit3 = load; bit0 = unsigned; bits[2:1] = 11 byte, 01 half, 10 word.
- FSM states: IDLE, BUS_REQ, BUS_WAIT, RESP; plus BUS_REQ2 and BUS_WAIT2 when the optional feature is compiled in.
- req_ready = (state == IDLE). The request is registered on acceptance.
- IDLE, accepted request, by case:
  - MEM_NOP → RESP, no bus activity.
  - Misaligned (half with addr[0]=1, word with addr[1:0]≠0) → RESP with rsp_err=1, cause 4 or 6, no bus activity.
  - Otherwise → BUS_REQ.
- BUS_REQ: mem_req=1; mem_addr, mem_be, mem_we and mem_wdata stay stable until the cycle mem_gnt=1, then → BUS_WAIT.
- BUS_WAIT: on mem_rvalid → RESP.
  - mem_err=1 gives a fault, cause 5 or 7.
  - Otherwise loads capture the extracted lane.
- mem_rvalid arriving in the grant cycle is not accepted; rvalid is sampled only in BUS_WAIT.
- RESP: rsp_valid=1 for exactly one cycle, then → IDLE. A new request is accepted in the next IDLE cycle.
- Byte enables: byte 0001<<addr[1:0]; half 0011<<addr[1:0]; word 1111.
- Store data replication: byte {4{b}}, half {2{h}}, word as-is.
- Load extraction: shift mem_rdata right by 8·addr[1:0], then sign- or zero-extend from 8 or 16 bits.
- Timeout (TIMEOUT>0):
  - Counter clears on leaving IDLE and increments each cycle in BUS_REQ/BUS_WAIT.
  - On reaching TIMEOUT: mem_req drops, fault cause 5/7, → RESP.
  - A stray mem_rvalid while IDLE or RESP is ignored.
- Minimum latency, aligned access with gnt in the first request cycle:
  - accept at cycle 0;
  - mem_req at cycle 1;
  - rvalid at cycle 2;
  - rsp_valid at cycle 3.
- Reset (any state, including mid-transaction):
  - next edge → IDLE;
  - mem_req, mem_we, mem_be, mem_addr, mem_wdata, rsp_valid, rsp_err, rsp_cause, rsp_rdata, busy all 0;
  - counter 0;
  - req_ready=1 after the reset edge;
  - any pending bus response is discarded.

Optional Feature:
MISALIGNED_SPLIT_EN.
- Defined:
  - Misaligned accesses inside one word (e.g. half at offset 1) issue a single transaction with shifted be (0110).
  - Word-crossing accesses (half at offset 3; word at offsets 1–3) issue two transactions.
    - First: word(addr), upper lanes.
    - Second: word(addr)+4, remaining lower lanes.
  - Load bytes are merged before extension.
  - An error in the first transaction aborts the second (a store may be partially written) and reports a fault.
  - The timeout counter restarts per transaction.
  - No misaligned exception is ever raised.
- Undefined: misaligned accesses raise exception 4/6 as above; BUS_REQ2 and BUS_WAIT2 are absent.

Test Plan:
- MEM_LB addr 0x103, mem_rdata 0x80FF_0000, gnt immediate → mem_be=1000; rsp_rdata 0xFFFF_FF80 at cycle 3.
- MEM_SH addr 0x202, wdata 0x0000_BEEF → mem_we=1, be=1100, mem_wdata 0xBEEF_BEEF, mem_addr 0x200; rsp_valid once, rsp_err=0.
- MEM_LW addr 0x101, split off → rsp_err=1, cause 4, mem_req never asserted; split on, rdata words 0x4433_2211 then 0x0000_0055 → rsp_rdata 0x5544_3322.
- MEM_SW, gnt delayed 3 cycles → mem_addr, be, wdata held stable; mem_rvalid with mem_err=1 → cause 7.
- MEM_LHU with no rvalid, TIMEOUT=16 → mem_req drops, rsp_err=1, cause 5; a late rvalid is ignored, and a following MEM_NOP responds with rdata 0.
- rst_n low during BUS_WAIT → next cycle IDLE, all outputs 0, req_ready=1; no rsp_valid for the aborted request.
